// File: rtl/flip_candidate_loader.sv
// Flip candidate loader: walks the NSAT literals of a broken clause, looks up
// each flipped literal in the clause table and writes one temporal-buffer row
// per candidate (flipped literal plus the other literals of the hit clause).
module flip_candidate_loader #(
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int NSAT_BITS             = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start_i,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]     clause_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          ct_req_o,
  output logic [LITERAL_ADDRESS_WIDTH:0]                ct_literal_o,
  input  logic                                          ct_ack_i,
  input  logic [(NSAT-1)*(LITERAL_ADDRESS_WIDTH+1)-1:0] ct_literals_i,
  output logic                                          tb_write_en_o,
  output logic [NSAT_BITS-1:0]                          tb_write_index_o,
  output logic [LITERAL_ADDRESS_WIDTH:0]                tb_flipped_literal_o,
  output logic [(NSAT-1)*(LITERAL_ADDRESS_WIDTH+1)-1:0] tb_clause_table_literals_o
);

  localparam int W = LITERAL_ADDRESS_WIDTH + 1;
  localparam logic [NSAT_BITS-1:0] LAST_K = NSAT_BITS'(NSAT - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NSAT_BITS-1:0]    k_q, k_d;
  logic [NSAT*W-1:0]       clause_q, clause_d;

  logic                    tb_write_en_q;
  logic [NSAT_BITS-1:0]    tb_write_index_q;
  logic [W-1:0]            tb_flipped_literal_q;
  logic [(NSAT-1)*W-1:0]   tb_ct_literals_q;

  logic [W-1:0]            cur_lit;
  logic [W-1:0]            flip_lit;
  logic                    empty_slot;
  logic                    complete;

  // Current candidate literal and its negated form; address 0 marks an empty slot.
  assign cur_lit    = clause_q[int'(k_q)*W +: W];
  assign flip_lit   = {~cur_lit[W-1], cur_lit[W-2:0]};
  assign empty_slot = (cur_lit[W-2:0] == '0);
  // An empty slot finishes without asking the table; otherwise wait for the ack.
  assign complete   = (state_q == LOOKUP) && (empty_slot || ct_ack_i);

  // State register, candidate counter and captured clause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      clause_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      clause_q <= clause_d;
    end
  end

  // Next-state logic: accept a clause in IDLE, step through candidates in LOOKUP.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    clause_d = clause_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOOKUP;
          k_d      = '0;
          clause_d = clause_i;
        end
      end
      LOOKUP: begin
        if (complete) begin
          if (k_q == LAST_K) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: request only for occupied slots, status from the state.
  always_comb begin
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    ct_req_o     = (state_q == LOOKUP) && !empty_slot;
    ct_literal_o = (state_q == LOOKUP) ? flip_lit : '0;
  end

  // Temporal-buffer row: strobe for one cycle per completion, data held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      tb_write_en_q        <= 1'b0;
      tb_write_index_q     <= '0;
      tb_flipped_literal_q <= '0;
      tb_ct_literals_q     <= '0;
    end else begin
      tb_write_en_q <= complete;
      if (complete) begin
        tb_write_index_q     <= k_q;
        tb_flipped_literal_q <= empty_slot ? '0 : flip_lit;
        tb_ct_literals_q     <= empty_slot ? '0 : ct_literals_i;
      end
    end
  end

  assign tb_write_en_o              = tb_write_en_q;
  assign tb_write_index_o           = tb_write_index_q;
  assign tb_flipped_literal_o       = tb_flipped_literal_q;
  assign tb_clause_table_literals_o = tb_ct_literals_q;

endmodule

// File: tb/tb_flip_candidate_loader.sv
// Scoreboard bench for flip_candidate_loader: the driver pushes expected rows,
// a negedge monitor pops and compares every temporal-buffer write.
module tb_flip_candidate_loader;

  localparam int NSAT = 3;
  localparam int LAW  = 11;
  localparam int NB   = 2;
  localparam int W    = LAW + 1;
  localparam logic [W-1:0] NEG = {1'b1, {(W-1){1'b0}}};

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start_i;
  logic [NSAT*W-1:0]     clause_i;
  logic                  busy_o, done_o, ct_req_o, ct_ack_i, tb_write_en_o;
  logic [W-1:0]          ct_literal_o, tb_flipped_literal_o;
  logic [(NSAT-1)*W-1:0] ct_literals_i, tb_clause_table_literals_o;
  logic [NB-1:0]         tb_write_index_o;

  flip_candidate_loader #(.NSAT(NSAT), .LITERAL_ADDRESS_WIDTH(LAW), .NSAT_BITS(NB)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .clause_i(clause_i),
    .busy_o(busy_o), .done_o(done_o), .ct_req_o(ct_req_o), .ct_literal_o(ct_literal_o),
    .ct_ack_i(ct_ack_i), .ct_literals_i(ct_literals_i), .tb_write_en_o(tb_write_en_o),
    .tb_write_index_o(tb_write_index_o), .tb_flipped_literal_o(tb_flipped_literal_o),
    .tb_clause_table_literals_o(tb_clause_table_literals_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NB-1:0]         idx;
    logic [W-1:0]          flip;
    logic [(NSAT-1)*W-1:0] lits;
    logic                  done;
  } row_t;

  row_t exp_q[$];
  row_t mon_row;
  logic [NB+W+(NSAT-1)*W-1:0] last_row;

  int                    dly [NSAT];
  logic [(NSAT-1)*W-1:0] data [NSAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a candidate is the literal with its sign flipped; empty slots write zero.
  function automatic logic [W-1:0] model_flip(input logic [W-1:0] lit);
    if (lit[W-2:0] == '0) return '0;
    return lit ^ NEG;
  endfunction

  // Monitor: every write must match the next expected row; data holds between writes.
  always @(negedge clk) begin
    if (reset) begin
      last_row = '0;
    end else if (tb_write_en_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got index %0d with no row expected at %0t",
                 tb_write_index_o, $time);
      end else begin
        mon_row = exp_q.pop_front();
        chk("write_index", 64'(tb_write_index_o), 64'(mon_row.idx));
        chk("flipped_literal", 64'(tb_flipped_literal_o), 64'(mon_row.flip));
        chk("table_literals", 64'(tb_clause_table_literals_o), 64'(mon_row.lits));
        chk("done_with_write", 64'(done_o), 64'(mon_row.done));
        $display("[TB] row %0d flip=%03h lits=%06h done=%0d", tb_write_index_o,
                 tb_flipped_literal_o, tb_clause_table_literals_o, done_o);
      end
      last_row = {tb_write_index_o, tb_flipped_literal_o, tb_clause_table_literals_o};
    end else begin
      chk("done_without_write", 64'(done_o), 64'd0);
      chk("row_hold", 64'({tb_write_index_o, tb_flipped_literal_o, tb_clause_table_literals_o}),
          64'(last_row));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one clause through the DUT. inject_k pulses start_i during that
  // candidate's wait; abort_k applies reset while waiting on that candidate.
  task automatic run_clause(input logic [NSAT*W-1:0] cl, input int inject_k, input int abort_k);
    logic [W-1:0] lit;
    logic [W-1:0] fl;
    row_t r;
    start_i  = 1'b1;
    clause_i = cl;
    tick();
    start_i  = 1'b0;
    clause_i = {$urandom, $urandom};
    chk("busy_after_start", 64'(busy_o), 64'd1);
    for (int k = 0; k < NSAT; k++) begin
      lit    = cl[k*W +: W];
      fl     = model_flip(lit);
      r.idx  = NB'(k);
      r.flip = fl;
      r.done = (k == NSAT - 1);
      if (lit[W-2:0] == '0) begin
        chk("empty_no_req", 64'(ct_req_o), 64'd0);
        ct_ack_i      = 1'($urandom_range(0, 1));
        ct_literals_i = (NSAT-1)*W'($urandom);
        r.lits        = '0;
        exp_q.push_back(r);
        tick();
      end else begin
        chk("req", 64'(ct_req_o), 64'd1);
        chk("ct_literal", 64'(ct_literal_o), 64'(fl));
        if (k == abort_k) begin
          ct_ack_i = 1'b0;
          tick();
          tick();
          reset = 1'b1;
          tick();
          chk("reset_outputs", 64'({busy_o, done_o, ct_req_o, tb_write_en_o, ct_literal_o}), 64'd0);
          reset         = 1'b0;
          ct_ack_i      = 1'b1;
          ct_literals_i = (NSAT-1)*W'($urandom);
          for (int c = 0; c < 3; c++) begin
            tick();
            chk("late_ack_ignored", 64'({busy_o, done_o, ct_req_o, tb_write_en_o}), 64'd0);
          end
          ct_ack_i = 1'b0;
          return;
        end
        for (int d = 0; d < dly[k]; d++) begin
          ct_ack_i = 1'b0;
          if (k == inject_k && d == 0) begin
            start_i  = 1'b1;
            clause_i = {$urandom, $urandom};
          end
          tick();
          start_i = 1'b0;
          chk("req_held", 64'(ct_req_o), 64'd1);
          chk("literal_held", 64'(ct_literal_o), 64'(fl));
        end
        ct_ack_i      = 1'b1;
        ct_literals_i = data[k];
        r.lits        = data[k];
        exp_q.push_back(r);
        tick();
      end
    end
    ct_ack_i = 1'b0;
    chk("done_state", 64'({busy_o, done_o}), 64'b11);
    tick();
    chk("idle_after_done", 64'({busy_o, done_o}), 64'd0);
  endtask

  task automatic set_timing(input int d0, input int d1, input int d2);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    for (int k = 0; k < NSAT; k++) data[k] = (NSAT-1)*W'($urandom);
  endtask

  function automatic logic [W-1:0] rand_lit();
    logic [W-1:0] l;
    l = W'($urandom);
    if ($urandom_range(0, 3) == 0) l[W-2:0] = '0;
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    start_i       = 1'b1;
    clause_i      = {12'h003, 12'h80A, 12'h005};
    ct_ack_i      = 1'b0;
    ct_literals_i = '0;
    tick();
    tick();
    chk("reset_state", 64'({busy_o, done_o, ct_req_o, tb_write_en_o, ct_literal_o}), 64'd0);
    chk("reset_tb_data", 64'({tb_write_index_o, tb_flipped_literal_o, tb_clause_table_literals_o}), 64'd0);
    start_i = 1'b0;
    reset   = 1'b0;
    tick();
    chk("idle_after_reset", 64'(busy_o), 64'd0);

    // Back-to-back candidates under immediate ack.
    set_timing(0, 0, 0);
    run_clause({12'h003, 12'h80A, 12'h005}, -1, -1);
    // Delayed ack on candidate 1.
    set_timing(0, 4, 0);
    run_clause({12'h003, 12'h80A, 12'h005}, -1, -1);
    // Empty slot 2.
    set_timing(1, 0, 0);
    run_clause({12'h800, 12'h80A, 12'h005}, -1, -1);
    // start_i while busy must be ignored.
    set_timing(0, 3, 1);
    run_clause({12'h123, 12'h456, 12'h789}, 1, -1);
    // Reset while waiting on candidate 1, then a clean run.
    set_timing(0, 5, 0);
    run_clause({12'h003, 12'h80A, 12'h005}, -1, 1);
    tick();
    chk("rows_after_abort", 64'(exp_q.size()), 64'd0);
    set_timing(0, 0, 0);
    run_clause({12'h003, 12'h80A, 12'h005}, -1, -1);

    // Randomized clauses, latencies and stray starts.
    for (int t = 0; t < 40; t++) begin
      set_timing($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_clause({rand_lit(), rand_lit(), rand_lit()},
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NSAT-1)) : -1, -1);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        ct_ack_i = 1'($urandom_range(0, 1));
        tick();
      end
      ct_ack_i = 1'b0;
    end

    tick();
    chk("rows_outstanding", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
